// File: rtl/crypto_pkg.sv
// crypto_pkg
// Shared definitions for the block load/unload datapaths.
//   - Default block geometry (words per block, bits per word) and the
//     derived BLOCK_SIZE / WORD_BYTES values.
//   - The EMPTY/FULL holding-state encoding.
//   - bswap_word: byte reversal of the low nbytes bytes of a word. The
//     key-loading RAM and the block unpacker both use it, so the two
//     directions always agree on byte order.
// No ports (package).
package crypto_pkg;

  localparam int DEF_WORDS     = 4;
  localparam int DEF_WORD_SIZE = 32;
  localparam int BLOCK_SIZE    = DEF_WORDS * DEF_WORD_SIZE;
  localparam int WORD_BYTES    = DEF_WORD_SIZE / 8;

  // Widest word bswap_word can handle; narrower words are zero-padded.
  localparam int MAX_WORD_W    = 256;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } blk_state_e;

  // Reverses the order of the lowest nbytes bytes of w; upper bits of the
  // result are zero.
  function automatic logic [MAX_WORD_W-1:0] bswap_word(
    input logic [MAX_WORD_W-1:0] w,
    input int                    nbytes
  );
    logic [MAX_WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WORD_W / 8; i++) begin
      if (i < nbytes) begin
        r[i*8 +: 8] = w[(nbytes-1-i)*8 +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/word_bswap.sv
// word_bswap
// Purely combinational byte reversal of one word.
// Parameters:
//   WORD_SIZE  bits per word, multiple of 8, at most crypto_pkg::MAX_WORD_W
// Ports:
//   word_i  input word
//   word_o  same word with its bytes in reverse order
module word_bswap
  import crypto_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] word_i,
  output logic [WORD_SIZE-1:0] word_o
);

  assign word_o = WORD_SIZE'(bswap_word(MAX_WORD_W'(word_i), WORD_SIZE / 8));

endmodule

// File: rtl/block_unpacker.sv
// block_unpacker
// Captures one big-endian block from the cipher core, holds it, and returns
// it one little-endian word per read request (byte-swapped back). A FULL
// state blocks further captures until every word has been read or the host
// releases the block early.
//
// Parameters:
//   WORDS      words per block
//   WORD_SIZE  bits per word (multiple of 8)
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   in_valid     core offers a block
//   in_block     big-endian block, word 0 in the top bits
//   in_ready     block can be accepted this cycle
//   ren          word read request
//   ridx         word index, 0 is the first word
//   release_blk  discard the held block early
//   rdata        registered read data (holds between reads)
//   rvalid       one-cycle pulse, rdata valid
//   rerr         the read that produced rdata was illegal
//   full         a block is held
//
// Build option: define BLOCK_UNPACKER_SCRUB_EN to zero the held block on
// every transition to EMPTY and to return zero data for reads in EMPTY.
// Without it the block stays until the next capture and EMPTY reads return
// the stale word.
module block_unpacker
  import crypto_pkg::*;
#(
  parameter int WORDS     = DEF_WORDS,
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WORDS*WORD_SIZE-1:0] in_block,
  output logic                       in_ready,
  input  logic                       ren,
  input  logic [$clog2(WORDS)-1:0]   ridx,
  input  logic                       release_blk,
  output logic [WORD_SIZE-1:0]       rdata,
  output logic                       rvalid,
  output logic                       rerr,
  output logic                       full
);

  localparam int BLK_W = WORDS * WORD_SIZE;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W:0] WORDS_L = WORDS[IDX_W:0];

`ifdef BLOCK_UNPACKER_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  blk_state_e           state_q, state_d;
  logic [WORDS-1:0]     mask_q, mask_d;
  logic [BLK_W-1:0]     blk_q, blk_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rerr_q, rerr_d;

  logic [WORD_SIZE-1:0] words [WORDS];
  logic [WORD_SIZE-1:0] sel_word;
  logic [WORD_SIZE-1:0] swapped;
  logic                 idx_ok;
  logic                 capture;
  logic                 legal_rd;

  // Word k sits at the k-th slot counted from the top of the block.
  for (genvar k = 0; k < WORDS; k++) begin : g_words
    assign words[k] = blk_q[(WORDS-k)*WORD_SIZE-1 -: WORD_SIZE];
  end

  assign idx_ok   = ({1'b0, ridx} < WORDS_L);
  assign sel_word = idx_ok ? words[ridx] : '0;

  word_bswap #(
    .WORD_SIZE(WORD_SIZE)
  ) u_bswap (
    .word_i(sel_word),
    .word_o(swapped)
  );

  assign in_ready = (state_q == ST_EMPTY) && !rst;
  assign capture  = in_valid && in_ready;
  assign legal_rd = ren && (state_q == ST_FULL) && idx_ok;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    blk_d    = blk_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    rvalid_d = ren;

    if (ren) begin
      if (legal_rd) begin
        rdata_d      = swapped;
        rerr_d       = 1'b0;
        mask_d[ridx] = 1'b1;
      end else begin
        // Out-of-range index selects zero; EMPTY reads expose the stale
        // word unless scrubbing is enabled.
        rerr_d  = 1'b1;
        rdata_d = SCRUB ? '0 : swapped;
      end
    end

    // A read in the same cycle as release_blk is still served above from
    // the current block; only the state changes here.
    if (state_q == ST_FULL) begin
      if (release_blk || (legal_rd && (mask_d == '1))) begin
        state_d = ST_EMPTY;
        if (SCRUB) begin
          blk_d = '0;
        end
      end
    end

    if (capture) begin
      blk_d   = in_block;
      mask_d  = '0;
      state_d = ST_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      mask_q   <= '0;
      blk_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      blk_q    <= blk_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rerr   = rerr_q;
  assign full   = (state_q == ST_FULL);

endmodule

// File: tb/tb_block_unpacker.sv
// tb_block_unpacker
// Directed bench for block_unpacker (WORDS=4, WORD_SIZE=32). Inputs change
// 1 time unit after a rising edge; outputs are observed at that same point,
// so they reflect the edge just taken.
module tb_block_unpacker;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_block;
  logic         in_ready;
  logic         ren;
  logic [1:0]   ridx;
  logic         release_blk;
  logic [31:0]  rdata;
  logic         rvalid;
  logic         rerr;
  logic         full;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF_01020304_A5A5C3C3_0F1E2D3C;

  logic [31:0] a_words [4];
  logic [31:0] stale_w1;

  block_unpacker #(
    .WORDS(4),
    .WORD_SIZE(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_block(in_block),
    .in_ready(in_ready),
    .ren(ren),
    .ridx(ridx),
    .release_blk(release_blk),
    .rdata(rdata),
    .rvalid(rvalid),
    .rerr(rerr),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [127:0] blk);
    in_valid = 1'b1;
    in_block = blk;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx);
    ren  = 1'b1;
    ridx = idx;
    tick();
    ren  = 1'b0;
  endtask

  initial begin
    a_words[0] = 32'h33221100;
    a_words[1] = 32'h77665544;
    a_words[2] = 32'hBBAA9988;
    a_words[3] = 32'hFFEEDDCC;
`ifdef BLOCK_UNPACKER_SCRUB_EN
    stale_w1 = 32'h0;
`else
    stale_w1 = 32'h77665544;
`endif

    rst = 1'b1; in_valid = 1'b0; in_block = '0; ren = 1'b0; ridx = '0; release_blk = 1'b0;
    tick();
    tick();
    chk("rst_full",     {31'b0, full},     32'd0);
    chk("rst_rvalid",   {31'b0, rvalid},   32'd0);
    chk("rst_rerr",     {31'b0, rerr},     32'd0);
    chk("rst_rdata",    rdata,             32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic unload
    capture(BLK_A);
    chk("cap_full",     {31'b0, full},     32'd1);
    chk("cap_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      chk($sformatf("basic_rdata%0d", i), rdata, a_words[i]);
      chk($sformatf("basic_rvalid%0d", i), {31'b0, rvalid}, 32'd1);
      chk($sformatf("basic_rerr%0d", i), {31'b0, rerr}, 32'd0);
      if (i < 3) chk($sformatf("basic_full%0d", i), {31'b0, full}, 32'd1);
    end
    chk("basic_release",  {31'b0, full},     32'd0);
    chk("basic_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("hold_rvalid", {31'b0, rvalid}, 32'd0);
    chk("hold_rdata",  rdata,           32'hFFEEDDCC);

    // Hold while full: B waits until A is fully read
    capture(BLK_A);
    in_valid = 1'b1;
    in_block = BLK_B;
    #1;
    chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ren = 1'b1; ridx = 2'(i);
      tick();
      chk($sformatf("hold_rdata%0d", i), rdata, a_words[i]);
    end
    ren = 1'b0;
    chk("hold_emptied",  {31'b0, full},     32'd0);
    chk("hold_ready_up", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("hold_b_full", {31'b0, full}, 32'd1);
    rd(2'd0);
    chk("hold_b_word0", rdata, 32'hEFBEADDE);
    release_blk = 1'b1;
    tick();
    release_blk = 1'b0;
    chk("hold_b_released", {31'b0, full}, 32'd0);

    // Re-read and order
    capture(BLK_A);
    rd(2'd2);
    chk("rr_idx2a", rdata, 32'hBBAA9988);
    rd(2'd2);
    chk("rr_idx2b", rdata, 32'hBBAA9988);
    chk("rr_full_a", {31'b0, full}, 32'd1);
    rd(2'd3);
    chk("rr_idx3", rdata, 32'hFFEEDDCC);
    rd(2'd0);
    chk("rr_idx0", rdata, 32'h33221100);
    chk("rr_full_b", {31'b0, full}, 32'd1);
    rd(2'd1);
    chk("rr_idx1", rdata, 32'h77665544);
    chk("rr_release", {31'b0, full}, 32'd0);

    // Early release together with a read
    capture(BLK_A);
    rd(2'd0);
    chk("er_idx0", rdata, 32'h33221100);
    ren = 1'b1; ridx = 2'd1; release_blk = 1'b1;
    tick();
    ren = 1'b0; release_blk = 1'b0;
    chk("er_rdata", rdata, 32'h77665544);
    chk("er_rerr",  {31'b0, rerr}, 32'd0);
    chk("er_full",  {31'b0, full}, 32'd0);
    rd(2'd1);
    chk("er_empty_rvalid", {31'b0, rvalid}, 32'd1);
    chk("er_empty_rerr",   {31'b0, rerr},   32'd1);
    chk("er_empty_rdata",  rdata,           stale_w1);

    // Reset in the middle of a read
    capture(BLK_A);
    chk("mr_full_pre", {31'b0, full}, 32'd1);
    ren = 1'b1; ridx = 2'd0; rst = 1'b1;
    tick();
    ren = 1'b0;
    chk("mr_rvalid", {31'b0, rvalid}, 32'd0);
    chk("mr_rdata",  rdata,           32'd0);
    chk("mr_full",   {31'b0, full},   32'd0);
    rst = 1'b0;
    #1;
    chk("mr_in_ready", {31'b0, in_ready}, 32'd1);
    rd(2'd0);
    chk("mr_empty_rerr",  {31'b0, rerr}, 32'd1);
    chk("mr_empty_rdata", rdata,         32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
